// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the uart_tx holding register.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/stop frame FSM
// advanced by the baud generator's tick; LSB first, tx idles high.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_q        <= 1'b1;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;

    // Accept needs an empty holder and a load needs a full one, so they never collide.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            tx_d        = 1'b0;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            state_d     = StData;
          end else begin
            tx_d = 1'b1;
          end
        end
        StData: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StStop: begin
          tx_d = 1'b1;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.tx_ready = ~hold_full_q;
  assign tx           = tx_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) checked every clock against a
// bit-list reference model of the serial line and the holding register.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic tx0, tx1, busy0, busy1;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_if #(.DATA_BITS(8)) bus1 ();

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .bus  (bus0),
    .tx   (tx0),
    .busy (busy0)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .bus  (bus1),
    .tx   (tx1),
    .busy (busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each frame is a list of line levels, one per tick period.
  logic       line_q [2][$];
  logic       held_v [2];
  logic [7:0] held_d [2];
  logic       m_tx   [2];

  function automatic void model_step(int k, logic r, logic t, logic v, logic [7:0] d);
    logic rdy;
    rdy = !held_v[k];
    if (r) begin
      line_q[k].delete();
      held_v[k] = 1'b0;
      m_tx[k]   = 1'b1;
      return;
    end
    if (t) begin
      if (line_q[k].size() == 0 && held_v[k]) begin
        line_q[k].push_back(1'b0);
        for (int i = 0; i < 8; i++) line_q[k].push_back(held_d[k][i]);
        for (int s = 0; s <= k; s++) line_q[k].push_back(1'b1);
        held_v[k] = 1'b0;
      end
      if (line_q[k].size() != 0) m_tx[k] = line_q[k].pop_front();
      else m_tx[k] = 1'b1;
    end
    if (v && rdy) begin
      held_v[k] = 1'b1;
      held_d[k] = d;
    end
  endfunction

  int tick_per   = 4;
  int tick_ph    = 0;
  bit rand_tick  = 1'b0;

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    logic t;
    if (rand_tick) begin
      t = ($urandom_range(0, 3) == 0);
    end else begin
      t       = (tick_ph == tick_per - 1);
      tick_ph = (tick_ph == tick_per - 1) ? 0 : tick_ph + 1;
    end
    rst           = r;
    tick          = t;
    bus0.tx_valid = v;
    bus1.tx_valid = v;
    bus0.tx_data  = d;
    bus1.tx_data  = d;
    @(posedge clk);
    model_step(0, r, t, v, d);
    model_step(1, r, t, v, d);
    @(negedge clk);
    check_eq("tx0",    32'(tx0),           32'(m_tx[0]));
    check_eq("ready0", 32'(bus0.tx_ready), 32'(!held_v[0]));
    check_eq("busy0",  32'(busy0),         32'(line_q[0].size() != 0));
    check_eq("tx1",    32'(tx1),           32'(m_tx[1]));
    check_eq("ready1", 32'(bus1.tx_ready), 32'(!held_v[1]));
    check_eq("busy1",  32'(busy1),         32'(line_q[1].size() != 0));
  endtask

  // Present bytes in order with valid held; advance when instance 0 accepts.
  task automatic send_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n);
    logic [7:0] bytes [3];
    int idx;
    int guard;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 400) begin
      logic acc;
      acc = !held_v[0];
      drive(1'b0, 1'b1, bytes[idx]);
      if (acc) idx++;
      guard++;
    end
    check_eq("stream_accepts", 32'(idx), 32'(n));
  endtask

  initial begin
    held_v[0] = 1'b0;
    held_v[1] = 1'b0;
    m_tx[0]   = 1'b1;
    m_tx[1]   = 1'b1;
    held_d[0] = '0;
    held_d[1] = '0;

    // Reset with tick and valid toggling.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 8'h00);

    // Single 0xA5, tick every 4 clocks.
    tick_per = 4;
    send_stream(8'hA5, 8'h00, 8'h00, 1);
    for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, 8'($urandom));

    // Back-to-back 0x00 then 0xFF.
    send_stream(8'h00, 8'hFF, 8'h00, 2);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 8'($urandom));

    // Stall: three bytes with valid held throughout.
    send_stream(8'h12, 8'h34, 8'h56, 3);
    for (int i = 0; i < 130; i++) drive(1'b0, 1'b0, 8'($urandom));

    // Reset mid-frame on data bit 3 of 0x3C with 0x81 held.
    begin
      int guard;
      send_stream(8'h3C, 8'h81, 8'h00, 2);
      guard = 0;
      while (line_q[0].size() != 5 && guard < 100) begin
        drive(1'b0, 1'b0, 8'h00);
        guard++;
      end
      check_eq("midframe_reach", 32'(line_q[0].size()), 32'd5);
      check_eq("midframe_held", 32'(held_v[0]), 32'd1);
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, 8'h00);
    end

    // Two stop bits: 0x55 then a queued byte right behind it.
    send_stream(8'h55, 8'hC3, 8'h00, 2);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 8'h00);

    // Randomized traffic across tick periods, with rare resets.
    for (int blk = 0; blk < 15; blk++) begin
      tick_per  = $urandom_range(1, 6);
      tick_ph   = 0;
      rand_tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 200; i++) begin
        drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
      end
    end
    rand_tick = 1'b0;
    for (int i = 0; i < 150; i++) drive(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
